// File: rtl/iomem_responder.sv
// iomem_responder: block RAM endpoint for the core's iomem port.
// Answers each request with one ready pulse LATENCY cycles after acceptance.
module iomem_responder #(
  parameter int XLEN      = 32,
  parameter int BLK_SIZE  = 128,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 4,
  parameter     INIT_FILE = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iomem_valid_i,
  input  logic [XLEN-1:0]       iomem_addr_i,
  input  logic [BLK_SIZE/8-1:0] iomem_wstrb_i,
  input  logic [BLK_SIZE-1:0]   iomem_wdata_i,
  output logic                  iomem_ready_o,
  output logic [BLK_SIZE-1:0]   iomem_rdata_o,
  output logic                  busy_o
);

  localparam int NB  = BLK_SIZE / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = $clog2(LATENCY + 1);

  if (LATENCY < 1) begin : g_bad_lat
    $error("iomem_responder: LATENCY must be >= 1");
  end
  if ((1 << IW) != DEPTH) begin : g_bad_depth
    $error("iomem_responder: DEPTH must be a power of two");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  logic [BLK_SIZE-1:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NB-1:0]       wstrb_q, wstrb_d;
  logic [BLK_SIZE-1:0] wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic [BLK_SIZE-1:0] rdata_q, rdata_d;
  logic [BLK_SIZE-1:0] merged;
  logic                mem_we;

  // Address bits outside the block index only alias.
  logic unused_addr;
  assign unused_addr = ^{iomem_addr_i[XLEN-1:IW+OFF],
                         iomem_addr_i[OFF-1:0]};

  // Captured request's block with its strobed bytes overlaid.
  always_comb begin
    merged = mem[idx_q];
    for (int i = 0; i < NB; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Next-state: capture in IDLE, count down in BUSY, one-cycle RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iomem_valid_i) begin
          idx_d   = iomem_addr_i[IW+OFF-1:OFF];
          wstrb_d = iomem_wstrb_i;
          wdata_d = iomem_wdata_i;
          cnt_d   = CW'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          mem_we  = |wstrb_q;
          rdata_d = merged;
          ready_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Control and request registers; reset drops any pending request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Array commit on the final BUSY edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx_q] <= merged;
  end

  assign iomem_ready_o = ready_q;
  assign iomem_rdata_o = rdata_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_iomem_responder.sv
// tb_iomem_responder: scoreboard bench for iomem_responder.
// Expected blocks come from a byte-merge model of the array.
module tb_iomem_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [31:0]  addr;
  logic [15:0]  wstrb;
  logic [127:0] wdata;
  logic         ready;
  logic [127:0] rdata;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int npush  = 0;
  int nresp  = 0;

  logic [127:0] sb [$];
  logic [127:0] model [int];

  iomem_responder #(
    .XLEN(32), .BLK_SIZE(128), .DEPTH(DEPTH),
    .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .iomem_valid_i(valid),
    .iomem_addr_i(addr),
    .iomem_wstrb_i(wstrb),
    .iomem_wdata_i(wdata),
    .iomem_ready_o(ready),
    .iomem_rdata_o(rdata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ready) begin
      nresp++;
      if (sb.size() == 0) chk("unexpected_ready", 1, 0);
      else chk("rdata", rdata, sb.pop_front());
    end
  end

  // mode 0: drop valid after accept
  // mode 1: hold valid, scramble inputs while busy
  // mode 2: keep valid high to chain the next request
  task automatic do_req(input logic [31:0]  a,
                        input logic [15:0]  s,
                        input logic [127:0] d,
                        input int           mode);
    logic [127:0] exp;
    int ix;
    ix  = int'((a >> 4) & (DEPTH - 1));
    exp = model.exists(ix) ? model[ix] : '0;
    for (int b = 0; b < 16; b++)
      if (s[b]) exp[8*b +: 8] = d[8*b +: 8];
    if (s != '0) model[ix] = exp;
    sb.push_back(exp);
    npush++;
    valid = 1'b1;
    addr  = a;
    wstrb = s;
    wdata = d;
    @(posedge clk); #1;
    chk("busy_acc", busy, 1);
    if (mode == 0) valid = 1'b0;
    if (mode == 1) begin
      addr  = 32'h0;
      wstrb = '1;
      wdata = ~d;
    end
    for (int i = 1; i <= LAT + 1; i++) begin
      @(posedge clk); #1;
      chk("ready_t", ready, (i == LAT) ? 1 : 0);
      if (i == LAT && mode == 1) valid = 1'b0;
      if (i == LAT + 1) begin
        chk("busy_idle", busy, 0);
        chk("hold", rdata, exp);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    addr  = '0;
    wstrb = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: full write then read back
    do_req(32'h40, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
    do_req(32'h40, 16'h0000, 128'h0, 0);
    // T2: low-byte partial write
    do_req(32'h40, 16'h000F, {128{1'b1}}, 0);
    chk("t2_const", rdata, 128'h0123456789ABCDEF01234567FFFFFFFF);

    do_req(32'h00, 16'hFFFF, 128'hA5A5A5A5_00000000_11111111_22222222, 0);
    do_req(32'h10, 16'hFFFF, 128'h5A5A5A5A_33333333_44444444_55555555, 0);
    do_req(32'h80, 16'hFFFF, 128'hDEADBEEF_CAFEF00D_01020304_05060708, 0);

    // T3: back-to-back reads with valid held high
    do_req(32'h00, 16'h0000, 128'h0, 2);
    do_req(32'h10, 16'h0000, 128'h0, 0);

    // T4: inputs scrambled while busy
    do_req(32'h20, 16'hFFFF, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 1);
    do_req(32'h20, 16'h0000, 128'h0, 0);
    do_req(32'h00, 16'h0000, 128'h0, 0);
    do_req(32'h10, 16'h3C00, 128'hFFEEDDCC_BBAA9988_77665544_33221100, 0);

    // T5: aliasing modulo DEPTH*16 bytes
    do_req(32'h4000, 16'hFFFF, 128'h13579BDF_2468ACE0_FEDCBA98_76543210, 0);
    do_req(32'h0, 16'h0000, 128'h0, 0);
    do_req(32'h4, 16'h0000, 128'h0, 0);

    // T6: reset during a busy write
    valid = 1'b1;
    addr  = 32'h80;
    wstrb = '1;
    wdata = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_ready", ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #1;
      chk("t6_noready", ready, 0);
    end
    do_req(32'h80, 16'h0000, 128'h0, 0);
    do_req(32'h40, 16'h0000, 128'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 128'(sb.size()), 0);
    chk("resp_cnt", 128'(nresp), 128'(npush));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
